// File: rtl/lut_fifo_pkg.sv
// Sizing helpers for lut_fifo: pointers carry one extra wrap bit above the address.
package lut_fifo_pkg;

    localparam int LUT_FIFO_DEFAULT_DEPTH = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Core-wide architectural constants shared by the RV32I datapath and its helper blocks.
package riscv_32i_defs_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/lut_ram.sv
// Distributed-RAM style storage: synchronous write, asynchronous (combinational) read.
module lut_ram #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(LUT_DEPTH)-1:0] wr_addr,
    input  logic [LUT_WIDTH-1:0]         wr_data,
    input  logic [$clog2(LUT_DEPTH)-1:0] rd_addr,
    output logic [LUT_WIDTH-1:0]         rd_data
);

    logic [LUT_WIDTH-1:0] mem_q [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lut_fifo.sv
// First-word-fall-through FIFO over lut_ram; the head is read combinationally at rd_ptr.
// Optional registered almost_full/almost_empty flags are enabled with LUT_FIFO_ALMOST_FLAGS_EN.
module lut_fifo
    import riscv_32i_defs_pkg::*;
    import lut_fifo_pkg::*;
#(
    parameter int WIDTH            = XLEN,
    parameter int DEPTH            = LUT_FIFO_DEFAULT_DEPTH,
    parameter int ALMOST_FULL_LVL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef LUT_FIFO_ALMOST_FLAGS_EN
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty
`else
    output logic [$clog2(DEPTH):0]   count
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lut_fifo: DEPTH must be a power of two >= 2");
    end
    if (ALMOST_FULL_LVL > DEPTH || ALMOST_EMPTY_LVL < 0) begin : g_bad_lvl
        $error("lut_fifo: almost-flag levels out of range");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          empty, full, push, pop, wr_en;

    // Equal address with opposite wrap bits means the writer has lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & ~full;
    assign pop       = out_ready & ~empty;
    assign wr_en     = push & ~flush;
    assign count     = count_q;

    lut_ram #(
        .LUT_WIDTH (WIDTH),
        .LUT_DEPTH (DEPTH)
    ) u_lut_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (out_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef LUT_FIFO_ALMOST_FLAGS_EN
    logic almost_full_q, almost_empty_q;

    // Flags are computed from next occupancy so they line up with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (int'(count_d) >= ALMOST_FULL_LVL);
            almost_empty_q <= (int'(count_d) <= ALMOST_EMPTY_LVL);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: doc/lut_fifo.md
Name: lut_fifo

Overview:
- Synchronous first-word-fall-through FIFO built on the existing lut_ram (async read, sync write) as storage.
- Owns write/read pointers, occupancy and valid/ready handshakes; drives lut_ram wr_en/wr_addr/wr_data/rd_addr and consumes rd_data.
- First user: decoupling queue between core store path and data-memory bus; generic enough for fetch prefetch buffering.

Parameters:
- WIDTH, XLEN (32), data word width, passed to lut_ram LUT_WIDTH.
- DEPTH, 16, number of entries; power of two, >= 2; passed to lut_ram LUT_DEPTH.
- ALMOST_FULL_LVL, DEPTH-2, count at or above which almost_full asserts (optional feature only).
- ALMOST_EMPTY_LVL, 2, count at or below which almost_empty asserts (optional feature only).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers/count; wins over push/pop that cycle.
- in_valid  in  1  producer has in_data.
- in_ready  out  1  FIFO can accept; equals !full.
- in_data  in  WIDTH  write data.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  WIDTH  head entry, combinational from lut_ram rd_data.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  present only with LUT_FIFO_ALMOST_FLAGS_EN.
- almost_empty  out  1  present only with LUT_FIFO_ALMOST_FLAGS_EN.

Behaviour:
- State: wr_ptr, rd_ptr, each $clog2(DEPTH)+1 bits (address + wrap bit); count register.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0 -> in_ready=1, out_valid=0, almost_empty=1, almost_full=0. Storage contents not cleared; out_data undefined while out_valid=0.
- empty: wr_ptr==rd_ptr. full: address bits equal, wrap bits differ. count == wr_ptr-rd_ptr (mod 2*DEPTH) at all times.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- lut_ram hookup: wr_en=push, wr_addr=wr_ptr address bits, wr_data=in_data, rd_addr=rd_ptr address bits, out_data=rd_data.
- Push: entry written at posedge; wr_ptr+1. Pop: rd_ptr+1 at posedge. Pointer increment wraps naturally (address rolls DEPTH-1 -> 0, wrap bit toggles).
- Latency: word pushed at edge N is visible on out_data with out_valid=1 after edge N (zero extra cycles; FWFT).
- Simultaneous push+pop, 0<count<DEPTH: both pointers advance, count unchanged.
- Push while full: in_ready=0, no write, no pointer change. No pass-through when full.
- Pop while empty: out_valid=0, ignored. No bypass of in_data to out_data when empty.
- in_ready/out_valid depend only on registered state, never combinationally on in_valid/out_ready.
- flush=1 at posedge: pointers and count to 0, push/pop that cycle discarded (wr_en forced 0).
- Reset asserted mid-transfer: in-flight push/pop dropped; post-reset FIFO empty.

Optional Feature:
- Macro LUT_FIFO_ALMOST_FLAGS_EN.
- Defined: almost_full and almost_empty ports exist, registered, updated from next count: almost_full = (count_next >= ALMOST_FULL_LVL), almost_empty = (count_next <= ALMOST_EMPTY_LVL).
- Undefined: ports and logic absent; parameters ignored.

Decomposition:
- Shared package riscv_32i_defs_pkg supplies XLEN; add lut_fifo_pkg with ptr width helper constant and a lut_fifo_trans class (in_data/push/pop/out_data/count fields, compare/print) alongside lut_fifo_ref_model (queue-based) for the bench.
- One sub-module: existing lut_ram instance for storage; pointer/count logic stays in lut_fifo.

Test Plan:
- Reset then idle: count=0, out_valid=0, in_ready=1 for 5 cycles; almost_empty=1 when feature on.
- Push 0x11,0x22,0x33 back-to-back, no pop -> count=3, out_data=0x11 the cycle after first push; pop three -> out_data 0x11,0x22,0x33 in order, then out_valid=0.
- Fill DEPTH=16 with 0..15 -> in_ready=0, count=16; extra push 0xDEAD ignored; drain -> 0..15 exactly, no 0xDEAD.
- Hold count at 8, push+pop every cycle for 40 cycles (pointers wrap twice) -> count stays 8, output order matches ref model.
- Count=5, flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; next push 0x77 appears as head.
- Count=4, assert rst asynchronously mid-cycle -> out_valid=0 and count=0 immediately, before next clk edge.
